// File: rtl/fx_denorm64_if.sv
// Handshake bundle for fx_denorm64: normalized input beat in, denormalized result out.
// io_out_inexact exists only when FX_DENORM_STICKY_EN is defined.
interface fx_denorm64_if;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [63:0] io_in_mant;
    logic [5:0]  io_in_lz;
    logic        io_in_zero;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [63:0] io_out_data;
`ifdef FX_DENORM_STICKY_EN
    logic        io_out_inexact;
`endif

    modport slave (
        input  io_in_valid, io_in_mant, io_in_lz, io_in_zero, io_out_ready,
        output io_in_ready, io_out_valid, io_out_data
`ifdef FX_DENORM_STICKY_EN
        , output io_out_inexact
`endif
    );

    modport master (
        output io_in_valid, io_in_mant, io_in_lz, io_in_zero, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_data
`ifdef FX_DENORM_STICKY_EN
        , input io_out_inexact
`endif
    );
endinterface

// File: rtl/fx_denorm64.sv
// Two-stage denormalizer: out = mant >> lz (byte shift, then bit shift), zero forces 0.
// Optional sticky/inexact output enabled by defining FX_DENORM_STICKY_EN.
module fx_denorm64 #(
    parameter int WIDTH = 64
) (
    input  logic          clock,
    input  logic          reset,
    fx_denorm64_if.slave  io
);
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [2:0]       r_s1_lz_lo;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_byte_shift [8];
    logic [WIDTH-1:0] w_s1_data;
    logic [WIDTH-1:0] w_s2_data;

    // A full stage may still load when the stage after it drains this cycle.
    assign w_s2_load      = !r_s2_valid || io.io_out_ready;
    assign w_s1_load      = !r_s1_valid || w_s2_load;
    assign io.io_in_ready = w_s1_load;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte_shift
            assign w_byte_shift[gi] = io.io_in_mant >> (gi * 8);
        end
    endgenerate

    assign w_s1_data = io.io_in_zero ? '0 : w_byte_shift[io.io_in_lz[5:3]];
    assign w_s2_data = r_s1_data >> r_s1_lz_lo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_lz_lo <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= io.io_in_valid;
            if (io.io_in_valid) begin
                r_s1_data  <= w_s1_data;
                r_s1_lz_lo <= io.io_in_lz[2:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_s2_data;
            end
        end
    end

    assign io.io_out_valid = r_s2_valid;
    assign io.io_out_data  = r_s2_data;

`ifdef FX_DENORM_STICKY_EN
    logic             r_s1_inexact;
    logic             r_s2_inexact;
    logic [WIDTH-1:0] w_s1_lost_mask;
    logic [WIDTH-1:0] w_s2_lost_mask;
    logic             w_s1_inexact;
    logic             w_s2_inexact;

    // Masks cover exactly the low bits each stage discards.
    assign w_s1_lost_mask = ~({WIDTH{1'b1}} << {io.io_in_lz[5:3], 3'b000});
    assign w_s2_lost_mask = ~({WIDTH{1'b1}} << r_s1_lz_lo);
    assign w_s1_inexact   = !io.io_in_zero && (|(io.io_in_mant & w_s1_lost_mask));
    assign w_s2_inexact   = r_s1_inexact || (|(r_s1_data & w_s2_lost_mask));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_inexact <= 1'b0;
            r_s2_inexact <= 1'b0;
        end else begin
            if (w_s1_load && io.io_in_valid) begin
                r_s1_inexact <= w_s1_inexact;
            end
            if (w_s2_load && r_s1_valid) begin
                r_s2_inexact <= w_s2_inexact;
            end
        end
    end

    assign io.io_out_inexact = r_s2_inexact;
`endif
endmodule

// File: tb/tb_fx_denorm64.sv
// Bench for fx_denorm64: vector table, stall/reset sequences, random round-trip soak.
// Expected beats are queued on input transfer and checked on output transfer.
module tb_fx_denorm64;
    logic clock = 1'b0;
    logic reset;

    fx_denorm64_if u_if ();
    fx_denorm64 #(.WIDTH(64)) u_dut (
        .clock (clock),
        .reset (reset),
        .io    (u_if)
    );

    always #5 clock = ~clock;

`ifdef FX_DENORM_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct {
        logic [63:0] mant;
        logic [5:0]  lz;
        logic        zero;
        logic [63:0] data;
        logic        inex;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        inex;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] drv_exp_data = '0;
    logic        drv_exp_inex = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_inex = 1'b0;
    logic        rand_ready = 1'b0;

    function automatic logic out_inex();
`ifdef FX_DENORM_STICKY_EN
        return u_if.io_out_inexact;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int clz64(input logic [63:0] v);
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) return 63 - i;
        end
        return 0;
    endfunction

    // Scoreboard monitor: sample between edges, so handshake values are settled.
    always @(negedge clock) begin
        if (!reset) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (u_if.io_out_data !== prev_data || out_inex() !== prev_inex) begin
                    n_err++;
                    $display("FAIL hold: data=%h inex=%b required data=%h inex=%b",
                             u_if.io_out_data, out_inex(), prev_data, prev_inex);
                end
            end
            if (u_if.io_out_valid && u_if.io_out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: data=%h required no beat", u_if.io_out_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (u_if.io_out_data !== mon_e.data || out_inex() !== mon_e.inex) begin
                        n_err++;
                        $display("FAIL beat: data=%h inex=%b required data=%h inex=%b",
                                 u_if.io_out_data, out_inex(), mon_e.data, mon_e.inex);
                    end
                end
            end
            if (u_if.io_in_valid && u_if.io_in_ready) begin
                sb.push_back('{data: drv_exp_data, inex: drv_exp_inex & STICKY});
            end
            prev_stall = u_if.io_out_valid && !u_if.io_out_ready;
            prev_data  = u_if.io_out_data;
            prev_inex  = out_inex();
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) u_if.io_out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_in(input logic [63:0] mant, input logic [5:0] lz, input logic zero,
                          input logic [63:0] exp_data, input logic exp_inex);
        u_if.io_in_valid = 1'b1;
        u_if.io_in_mant  = mant;
        u_if.io_in_lz    = lz;
        u_if.io_in_zero  = zero;
        drv_exp_data     = exp_data;
        drv_exp_inex     = exp_inex;
    endtask

    // Idle inputs carry garbage that must not reach the output.
    task automatic go_idle();
        u_if.io_in_valid = 1'b0;
        u_if.io_in_mant  = {$urandom, $urandom};
        u_if.io_in_lz    = 6'($urandom_range(0, 63));
        u_if.io_in_zero  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_accept();
        logic acc;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clock);
            acc = u_if.io_in_ready;
            tick();
            if (acc) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: in_ready=0 required 1");
    endtask

    task automatic drain();
        for (int t = 0; t < 2000; t++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("drain_outstanding", 64'(sb.size()), 64'd0);
    endtask

    vec_t        vt[10];
    int          lat;
    logic [63:0] rv, rm;
    logic [5:0]  rl;
    logic        rz, ri;

    initial begin
        vt[0] = '{64'h8000_0000_0000_0000, 6'd63, 1'b0, 64'h0000_0000_0000_0001, 1'b0};
        vt[1] = '{64'hFFFF_0000_0000_0001, 6'd4,  1'b0, 64'h0FFF_F000_0000_0000, 1'b1};
        vt[2] = '{64'hDEAD_BEEF_0000_0000, 6'd5,  1'b1, 64'h0000_0000_0000_0000, 1'b0};
        vt[3] = '{64'h1234_5678_9ABC_DEF0, 6'd0,  1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0};
        vt[4] = '{64'h8000_0000_0000_00FF, 6'd8,  1'b0, 64'h0080_0000_0000_0000, 1'b1};
        vt[5] = '{64'hF000_0000_0000_0000, 6'd60, 1'b0, 64'h0000_0000_0000_000F, 1'b0};
        vt[6] = '{64'hC000_0000_0000_0001, 6'd56, 1'b0, 64'h0000_0000_0000_00C0, 1'b1};
        vt[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b0, 64'h0000_0000_0000_0001, 1'b1};
        vt[8] = '{64'h8000_0000_0000_0080, 6'd7,  1'b0, 64'h0100_0000_0000_0001, 1'b0};
        vt[9] = '{64'h8000_0000_0000_0040, 6'd7,  1'b0, 64'h0100_0000_0000_0000, 1'b1};

        reset             = 1'b0;
        u_if.io_in_valid  = 1'b0;
        u_if.io_in_mant   = '0;
        u_if.io_in_lz     = '0;
        u_if.io_in_zero   = 1'b0;
        u_if.io_out_ready = 1'b1;
        #3;
        check("reset_out_valid", 64'(u_if.io_out_valid), 64'd0);
        check("reset_out_data", u_if.io_out_data, 64'd0);
        check("reset_out_inexact", 64'(out_inex()), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_reset", 64'(u_if.io_in_ready), 64'd1);
        tick();

        // Latency: input presented in cycle k, result visible in cycle k+2.
        set_in(vt[0].mant, vt[0].lz, vt[0].zero, vt[0].data, vt[0].inex);
        @(negedge clock);
        tick();
        go_idle();
        lat = 1;
        while (lat < 10) begin
            @(negedge clock);
            if (u_if.io_out_valid) break;
            lat++;
            tick();
        end
        check("latency", 64'(lat), 64'd2);
        tick();

        for (int i = 1; i < 10; i++) begin
            set_in(vt[i].mant, vt[i].lz, vt[i].zero, vt[i].data, vt[i].inex);
            wait_accept();
        end
        go_idle();
        drain();

        // Stall: two beats fill the pipe, third must wait until out_ready rises.
        u_if.io_out_ready = 1'b0;
        set_in(64'hFEDC_BA98_7654_3210, 6'd0, 1'b0, 64'hFEDC_BA98_7654_3210, 1'b0);
        wait_accept();
        set_in(64'hFEDC_BA98_7654_3210, 6'd8, 1'b0, 64'h00FE_DCBA_9876_5432, 1'b1);
        wait_accept();
        set_in(64'hFEDC_BA98_7654_3210, 6'd9, 1'b0, 64'h007F_6E5D_4C3B_2A19, 1'b1);
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            check("stall_in_ready", 64'(u_if.io_in_ready), 64'd0);
            tick();
        end
        u_if.io_out_ready = 1'b1;
        wait_accept();
        go_idle();
        drain();

        // Reset mid-stall with two beats in flight.
        u_if.io_out_ready = 1'b0;
        set_in(64'h1111_2222_3333_4444, 6'd3, 1'b0, 64'h0222_2444_4666_6888, 1'b1);
        wait_accept();
        set_in(64'h8888_0000_0000_0000, 6'd1, 1'b0, 64'h4444_0000_0000_0000, 1'b0);
        wait_accept();
        go_idle();
        #2;
        check("inflight_valid", 64'(u_if.io_out_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("async_reset_valid", 64'(u_if.io_out_valid), 64'd0);
        check("async_reset_data", u_if.io_out_data, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        u_if.io_out_ready = 1'b1;
        @(negedge clock);
        check("ready_after_midreset", 64'(u_if.io_in_ready), 64'd1);
        for (int s = 0; s < 3; s++) begin
            check("no_stale_beat", 64'(u_if.io_out_valid), 64'd0);
            tick();
            @(negedge clock);
        end
        tick();

        // Soak: alternate CLZ round trips with raw random shifts, random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if (i % 2 == 0) begin
                rv = {$urandom, $urandom} >> $urandom_range(0, 63);
                rl = 6'(clz64(rv));
                set_in(rv << rl, rl, rv == 64'd0, rv, 1'b0);
            end else begin
                rm = {$urandom, $urandom};
                rl = 6'($urandom_range(0, 63));
                rz = ($urandom_range(0, 15) == 0);
                ri = !rz && (|(rm & ((64'd1 << rl) - 64'd1)));
                set_in(rm, rl, rz, rz ? 64'd0 : (rm >> rl), ri);
            end
            wait_accept();
            if ($urandom_range(0, 3) == 0) begin
                go_idle();
                tick();
            end
        end
        go_idle();
        rand_ready = 1'b0;
        u_if.io_out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
